bus_decoder: RTL and testbench
==============================

BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 Parameter N_SLAVES, default 8: number of slave ports, 1..16.
REQ-002 Parameter SLAVE_PREFIX, default {8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07} left-aligned to 12 bits: N_SLAVES x 12-bit packed prefix table.
REQ-003 Parameter SLAVE_PREFIX_LEN, default 8 per entry: N_SLAVES x 4-bit packed table of significant prefix bits per slave, 1..12.
REQ-004 Parameter TIMEOUT, default 1023: maximum cycles a slave may hold stall before the transfer is aborted.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 Port clk  in  1  system bus clock.
REQ-007 Port rst  in  1  asynchronous active-high reset.
REQ-008 Ports m_address in 32, m_read in 1, m_write in 1, m_data_wr in 32, m_mask in 4  master request, held stable while m_stall is high.
REQ-009 Ports m_stall out 1, m_data_rd out 32, m_interrupt out 6  master response and aggregated interrupts.
REQ-010 Ports s_address out 32, s_data_wr out 32, s_mask out 4  broadcast to all slaves.
REQ-011 Ports s_read out N_SLAVES, s_write out N_SLAVES  one-hot per-slave strobes.
REQ-012 Ports s_stall in N_SLAVES, s_data_rd in N_SLAVES*32, s_interrupt in N_SLAVES*6  per-slave responses.
REQ-013 Ports bus_error out 1, err_address out 32  sticky error flag and the first faulting address.
REQ-014 Port err_clear in 1  synchronous clear of bus_error and err_address.

Function
REQ-015 Decode: slave i matches when m_address[31 -: SLAVE_PREFIX_LEN[i]] equals the top SLAVE_PREFIX_LEN[i] bits of SLAVE_PREFIX[i]; on multiple matches the lowest index wins.
REQ-016 FSM states: IDLE, DECODE, ACTIVE, ERROR.
REQ-017 IDLE: on m_read or m_write, the block latches the decoded index and the request, asserts m_stall, and goes to DECODE; with both strobes asserted, write takes precedence.
REQ-018 DECODE (1 cycle): on a match, go to ACTIVE; on no match, go to ERROR; m_stall stays high.
REQ-019 ACTIVE: only the latched slave's s_read or s_write is driven; m_stall equals that slave's s_stall.
REQ-020 ACTIVE completes in the first cycle s_stall is low: m_data_rd takes that slave's s_data_rd (registered, valid the cycle m_stall falls), and the FSM returns to IDLE.
REQ-021 Minimum latency with a zero-wait slave is 2 cycles from request to m_stall low.
REQ-022 Timeout: a 10-bit-or-wider counter clears on entry to ACTIVE and increments while s_stall is high; when it reaches TIMEOUT, strobes drop and the FSM goes to ERROR.
REQ-023 ERROR (1 cycle): m_data_rd=32'hDEADBEEF, m_stall low, writes discarded; bus_error is set; err_address captures the latched address only if bus_error was previously clear; the FSM returns to IDLE.
REQ-024 Master abort: if m_read and m_write both drop in DECODE or ACTIVE, strobes deassert the next cycle, the FSM returns to IDLE, and no error is raised.
REQ-025 err_clear coinciding with a new error: the new error wins (flag set, address captured).
REQ-026 m_interrupt is the registered bitwise OR of all s_interrupt vectors, with 1-cycle latency.
REQ-027 s_read and s_write are all zero outside ACTIVE.

Reset
REQ-028 On rst: FSM=IDLE, m_stall=0, m_data_rd=0, m_interrupt=0, s_read=0, s_write=0, bus_error=0, err_address=0, timeout counter=0.
REQ-029 rst mid-transfer: strobes deassert immediately (asynchronously), and no error is recorded.

Structure
REQ-030 The FSM state enum, the 32'hDEADBEEF error word and the prefix-match width belong in the shared defs header beside Bus_if.
REQ-031 Prefix matching is a sub-module bus_prefix_match, combinational and parametrised by N_SLAVES, returning a valid flag and an index.

Verification
REQ-032 Read 0x0300_0004 with the UART slave (index 3) at zero wait, data 0x12345678 -> s_read[3] only; m_stall low on cycle 2; m_data_rd=0x12345678.
REQ-033 Write 0x0000_0010 with mask 4'b0011 and RAM stall for 3 cycles -> s_write[0] high for 4 cycles; s_mask=4'b0011; completion in cycle 5.
REQ-034 Read 0x0900_0000 (unmapped) -> ERROR; m_data_rd=0xDEADBEEF; bus_error=1; err_address=0x0900_0000; no slave strobe.
REQ-035 Slave 4 stall held high with TIMEOUT=15 -> abort after 15 stalled cycles; bus_error set; a second fault leaves err_address unchanged until err_clear.
REQ-036 Overlapping prefixes (slave 1 = 8'h1F, slave 2 = 12'h1FC) with address 0x1FC0_0000 -> slave 1 selected.
REQ-037 rst asserted during ACTIVE, and separately a master abort in DECODE -> all strobes drop, FSM returns to IDLE, bus_error stays 0.

Source files
------------

// File: rtl/bus_decoder_pkg.sv
// Shared definitions for the bus decoder: widths, FSM states, error word, request payload.
package bus_decoder_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MASK_W   = 4;
    localparam int unsigned IRQ_W    = 6;
    localparam int unsigned PREFIX_W = 12;
    localparam int unsigned PLEN_W   = 4;

    // Read data returned to the master for unmapped or timed-out transfers
    localparam logic [DATA_W-1:0] ERR_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ACTIVE,
        ST_ERROR
    } state_t;

    // Master request captured when a transfer is accepted
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
        logic              write;
    } bus_req_t;

    // Width of a slave index for n slaves (at least one bit)
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when the top len bits of addr_prefix equal the top len bits of prefix
    function automatic logic prefix_hit(input logic [PREFIX_W-1:0] addr_prefix,
                                        input logic [PREFIX_W-1:0] prefix,
                                        input logic [PLEN_W-1:0]   len);
        logic [PREFIX_W-1:0] mask;
        mask = ~({PREFIX_W{1'b1}} >> len);
        return ((addr_prefix ^ prefix) & mask) == '0;
    endfunction

endpackage

// File: rtl/bus_prefix_match.sv
// Combinational address-prefix decoder; the lowest matching slave index wins.
module bus_prefix_match
    import bus_decoder_pkg::*;
#(
    parameter int unsigned                        N_SLAVES         = 8,
    parameter logic [N_SLAVES*PREFIX_W-1:0]       SLAVE_PREFIX     = '0,
    parameter logic [N_SLAVES*PLEN_W-1:0]         SLAVE_PREFIX_LEN = '0,
    localparam int unsigned                       SEL_W            = sel_width(N_SLAVES)
) (
    input  logic [PREFIX_W-1:0] addr_prefix,
    output logic                hit,
    output logic [SEL_W-1:0]    idx
);

    // Scan upward and keep only the first match
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (!hit && prefix_hit(addr_prefix,
                                   SLAVE_PREFIX[i*PREFIX_W +: PREFIX_W],
                                   SLAVE_PREFIX_LEN[i*PLEN_W +: PLEN_W])) begin
                hit = 1'b1;
                idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_decoder.sv
// Single-master to N-slave bus decoder with timeout, sticky error capture and IRQ merge.
module bus_decoder
    import bus_decoder_pkg::*;
#(
    parameter int unsigned                  N_SLAVES         = 8,
    // Entry i lives at bits [i*12 +: 12]; default maps slave i to top byte 8'h0i
    parameter logic [N_SLAVES*PREFIX_W-1:0] SLAVE_PREFIX     = {12'h070, 12'h060, 12'h050, 12'h040,
                                                                12'h030, 12'h020, 12'h010, 12'h000},
    parameter logic [N_SLAVES*PLEN_W-1:0]   SLAVE_PREFIX_LEN = {8{4'd8}},
    parameter int unsigned                  TIMEOUT          = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            m_address,
    input  logic                         m_read,
    input  logic                         m_write,
    input  logic [DATA_W-1:0]            m_data_wr,
    input  logic [MASK_W-1:0]            m_mask,
    output logic                         m_stall,
    output logic [DATA_W-1:0]            m_data_rd,
    output logic [IRQ_W-1:0]             m_interrupt,
    output logic [ADDR_W-1:0]            s_address,
    output logic [DATA_W-1:0]            s_data_wr,
    output logic [MASK_W-1:0]            s_mask,
    output logic [N_SLAVES-1:0]          s_read,
    output logic [N_SLAVES-1:0]          s_write,
    input  logic [N_SLAVES-1:0]          s_stall,
    input  logic [N_SLAVES*DATA_W-1:0]   s_data_rd,
    input  logic [N_SLAVES*IRQ_W-1:0]    s_interrupt,
    output logic                         bus_error,
    output logic [ADDR_W-1:0]            err_address,
    input  logic                         err_clear
);

    localparam int unsigned SEL_W = sel_width(N_SLAVES);
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    state_t             state;
    bus_req_t           req_q;
    logic [SEL_W-1:0]   lat_idx;
    logic               lat_hit;
    logic [CNT_W-1:0]   tmo_cnt;

    logic               match_hit;
    logic [SEL_W-1:0]   match_idx;
    logic [N_SLAVES-1:0] sel_onehot;
    logic               sel_stall;
    logic [DATA_W-1:0]  sel_data;
    logic [IRQ_W-1:0]   irq_or;
    logic               req_live;
    logic               tmo_last;
    logic               err_set;

    bus_prefix_match #(
        .N_SLAVES         (N_SLAVES),
        .SLAVE_PREFIX     (SLAVE_PREFIX),
        .SLAVE_PREFIX_LEN (SLAVE_PREFIX_LEN)
    ) u_match (
        .addr_prefix (m_address[ADDR_W-1 -: PREFIX_W]),
        .hit         (match_hit),
        .idx         (match_idx)
    );

    assign s_address = req_q.addr;
    assign s_data_wr = req_q.data;
    assign s_mask    = req_q.mask;

    // Route the latched slave's stall/data and build its strobe vector
    always_comb begin
        sel_onehot = '0;
        sel_stall  = 1'b0;
        sel_data   = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (SEL_W'(i) == lat_idx) begin
                sel_onehot[i] = 1'b1;
                sel_stall     = s_stall[i];
                sel_data      = s_data_rd[i*DATA_W +: DATA_W];
            end
        end
    end

    // OR-merge of every slave interrupt vector
    always_comb begin
        irq_or = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            irq_or = irq_or | s_interrupt[i*IRQ_W +: IRQ_W];
        end
    end

    // A fault is raised on an unmatched decode or on the last permitted stall cycle
    always_comb begin
        req_live = m_read | m_write;
        tmo_last = (tmo_cnt == CNT_W'(TIMEOUT - 1));
        err_set  = ((state == ST_DECODE) && req_live && !lat_hit) ||
                   ((state == ST_ACTIVE) && req_live && sel_stall && tmo_last);
    end

    // Transfer FSM with all master/slave-facing outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            lat_idx     <= '0;
            lat_hit     <= 1'b0;
            tmo_cnt     <= '0;
            m_stall     <= 1'b0;
            m_data_rd   <= '0;
            m_interrupt <= '0;
            s_read      <= '0;
            s_write     <= '0;
            bus_error   <= 1'b0;
            err_address <= '0;
        end else begin
            m_interrupt <= irq_or;

            // A new fault overrides a coincident clear and re-arms address capture
            if (err_set) begin
                bus_error <= 1'b1;
                if (!bus_error || err_clear) begin
                    err_address <= req_q.addr;
                end
            end else if (err_clear) begin
                bus_error   <= 1'b0;
                err_address <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (req_live) begin
                        req_q   <= '{addr: m_address, data: m_data_wr, mask: m_mask, write: m_write};
                        lat_idx <= match_idx;
                        lat_hit <= match_hit;
                        m_stall <= 1'b1;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!req_live) begin
                        m_stall <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (lat_hit) begin
                        s_read  <= req_q.write ? '0 : sel_onehot;
                        s_write <= req_q.write ? sel_onehot : '0;
                        tmo_cnt <= '0;
                        state   <= ST_ACTIVE;
                    end else begin
                        m_stall   <= 1'b0;
                        m_data_rd <= ERR_WORD;
                        state     <= ST_ERROR;
                    end
                end
                ST_ACTIVE: begin
                    // m_stall stays high here and falls together with the captured read data
                    if (!req_live) begin
                        s_read  <= '0;
                        s_write <= '0;
                        m_stall <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (!sel_stall) begin
                        s_read  <= '0;
                        s_write <= '0;
                        m_stall <= 1'b0;
                        if (!req_q.write) begin
                            m_data_rd <= sel_data;
                        end
                        state <= ST_IDLE;
                    end else if (tmo_last) begin
                        s_read    <= '0;
                        s_write   <= '0;
                        m_stall   <= 1'b0;
                        m_data_rd <= ERR_WORD;
                        state     <= ST_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_ERROR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: table of transfers plus hand-written error, abort, IRQ and reset sequences.
module tb_bus_decoder;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    m_address;
    logic           m_read;
    logic           m_write;
    logic [31:0]    m_data_wr;
    logic [3:0]     m_mask;
    logic           m_stall;
    logic [31:0]    m_data_rd;
    logic [5:0]     m_interrupt;
    logic [31:0]    s_address;
    logic [31:0]    s_data_wr;
    logic [3:0]     s_mask;
    logic [N-1:0]   s_read;
    logic [N-1:0]   s_write;
    logic [N-1:0]   s_stall;
    logic [N*32-1:0] s_data_rd;
    logic [N*6-1:0] s_interrupt;
    logic           bus_error;
    logic [31:0]    err_address;
    logic           err_clear;

    int n_cmp = 0;
    int n_bad = 0;

    int          r_lat;
    int          r_strobes;
    logic [7:0]  r_rd_seen;
    logic [7:0]  r_wr_seen;
    logic [3:0]  r_mask_seen;
    logic [31:0] r_addr_seen;
    logic [31:0] r_wdata_seen;
    logic [31:0] r_data;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          stall_n;
        logic [7:0]  sel;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    bus_decoder #(
        .N_SLAVES         (8),
        .SLAVE_PREFIX     ({12'h070, 12'h060, 12'h050, 12'h040, 12'h030, 12'h1FC, 12'h1F0, 12'h000}),
        .SLAVE_PREFIX_LEN ({4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd12, 4'd8, 4'd8}),
        .TIMEOUT          (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_address   (m_address),
        .m_read      (m_read),
        .m_write     (m_write),
        .m_data_wr   (m_data_wr),
        .m_mask      (m_mask),
        .m_stall     (m_stall),
        .m_data_rd   (m_data_rd),
        .m_interrupt (m_interrupt),
        .s_address   (s_address),
        .s_data_wr   (s_data_wr),
        .s_mask      (s_mask),
        .s_read      (s_read),
        .s_write     (s_write),
        .s_stall     (s_stall),
        .s_data_rd   (s_data_rd),
        .s_interrupt (s_interrupt),
        .bus_error   (bus_error),
        .err_address (err_address),
        .err_clear   (err_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Run one master transfer; the addressed slave stalls its first stall_n strobe cycles.
    // abort_cyc / clr_cyc select the cycle after which the request drops / err_clear pulses.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input int stall_n, input int abort_cyc, input int clr_cyc);
        int cyc;
        logic [7:0] act;
        cyc          = 0;
        r_lat        = -1;
        r_strobes    = 0;
        r_rd_seen    = '0;
        r_wr_seen    = '0;
        r_mask_seen  = '0;
        r_addr_seen  = '0;
        r_wdata_seen = '0;
        m_address    = addr;
        m_data_wr    = wdata;
        m_mask       = mask;
        m_read       = rd;
        m_write      = wr;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            act = s_read | s_write;
            if (act != 8'h00) begin
                r_strobes++;
                r_rd_seen    = r_rd_seen | s_read;
                r_wr_seen    = r_wr_seen | s_write;
                r_mask_seen  = s_mask;
                r_addr_seen  = s_address;
                r_wdata_seen = s_data_wr;
            end
            if (!m_stall) begin
                r_lat = cyc - 1;
                break;
            end
            s_stall   = (r_strobes <= stall_n) ? act : 8'h00;
            err_clear = (cyc == clr_cyc);
            if (cyc == abort_cyc) begin
                m_read  = 1'b0;
                m_write = 1'b0;
            end
        end
        r_data    = m_data_rd;
        m_read    = 1'b0;
        m_write   = 1'b0;
        s_stall   = '0;
        err_clear = 1'b0;
        if (r_lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL xfer_done: m_stall still high after %0d cycles, expected low", cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0300_0004, wdata: 32'h0, mask: 4'hF, stall_n: 0,
                    sel: 8'h08, lat: 2, rdata: 32'h1234_5678, err: 1'b0};
        vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0010, wdata: 32'hCAFE_F00D, mask: 4'b0011, stall_n: 3,
                    sel: 8'h01, lat: 5, rdata: 32'h0, err: 1'b0};
        vecs[2] = '{rd: 1'b1, wr: 1'b0, addr: 32'h1FC0_0000, wdata: 32'h0, mask: 4'hF, stall_n: 0,
                    sel: 8'h02, lat: 2, rdata: 32'hA000_0001, err: 1'b0};
        vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0700_FFFC, wdata: 32'h0, mask: 4'hF, stall_n: 1,
                    sel: 8'h80, lat: 3, rdata: 32'hA000_0007, err: 1'b0};
        vecs[4] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0500_0000, wdata: 32'h5555_AAAA, mask: 4'b1100, stall_n: 2,
                    sel: 8'h20, lat: 4, rdata: 32'h0, err: 1'b0};
        vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 32'h1F00_0000, wdata: 32'h0, mask: 4'hF, stall_n: 0,
                    sel: 8'h02, lat: 2, rdata: 32'hA000_0001, err: 1'b0};
        vecs[6] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0900_0000, wdata: 32'h0, mask: 4'hF, stall_n: 0,
                    sel: 8'h00, lat: 1, rdata: 32'hDEAD_BEEF, err: 1'b1};

        rst         = 1'b1;
        m_address   = '0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_data_wr   = '0;
        m_mask      = '0;
        s_stall     = '0;
        s_interrupt = '0;
        err_clear   = 1'b0;
        for (int i = 0; i < N; i++) s_data_rd[i*32 +: 32] = 32'hA000_0000 | 32'(i);
        s_data_rd[3*32 +: 32] = 32'h1234_5678;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_stall",     32'(m_stall), 32'h0);
        check("rst_m_data_rd",   m_data_rd, 32'h0);
        check("rst_m_interrupt", 32'(m_interrupt), 32'h0);
        check("rst_s_read",      32'(s_read), 32'h0);
        check("rst_s_write",     32'(s_write), 32'h0);
        check("rst_bus_error",   32'(bus_error), 32'h0);
        check("rst_err_address", err_address, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table of single transfers
        for (int i = 0; i < 7; i++) begin
            xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].stall_n, 0, 0);
            check($sformatf("row%0d_s_read", i),  32'(r_rd_seen), (vecs[i].rd && !vecs[i].wr) ? 32'(vecs[i].sel) : 32'h0);
            check($sformatf("row%0d_s_write", i), 32'(r_wr_seen), vecs[i].wr ? 32'(vecs[i].sel) : 32'h0);
            check($sformatf("row%0d_strobe_cycles", i), 32'(r_strobes),
                  (vecs[i].sel != 8'h00) ? 32'(vecs[i].stall_n + 1) : 32'h0);
            check($sformatf("row%0d_latency", i), 32'(r_lat), 32'(vecs[i].lat));
            check($sformatf("row%0d_bus_error", i), 32'(bus_error), 32'(vecs[i].err));
            if (vecs[i].rd && !vecs[i].wr)
                check($sformatf("row%0d_m_data_rd", i), r_data, vecs[i].rdata);
            if (vecs[i].sel != 8'h00) begin
                check($sformatf("row%0d_s_mask", i), 32'(r_mask_seen), 32'(vecs[i].mask));
                check($sformatf("row%0d_s_address", i), r_addr_seen, vecs[i].addr);
            end
            if (vecs[i].wr)
                check($sformatf("row%0d_s_data_wr", i), r_wdata_seen, vecs[i].wdata);
        end
        check("unmapped_err_address", err_address, 32'h0900_0000);

        // Second fault keeps the first address; err_clear then wipes both
        xfer(1'b1, 1'b0, 32'h0A00_0000, 32'h0, 4'hF, 0, 0, 0);
        check("fault2_err_address", err_address, 32'h0900_0000);
        pulse_clear();
        check("clear_bus_error",   32'(bus_error), 32'h0);
        check("clear_err_address", err_address, 32'h0);

        // Slave 4 never releases stall: aborted after 15 stalled cycles
        xfer(1'b1, 1'b0, 32'h0400_0100, 32'h0, 4'hF, 1000, 0, 0);
        check("tmo_s_read",        32'(r_rd_seen), 32'h10);
        check("tmo_strobe_cycles", 32'(r_strobes), 32'd15);
        check("tmo_latency",       32'(r_lat), 32'd16);
        check("tmo_m_data_rd",     r_data, 32'hDEAD_BEEF);
        check("tmo_bus_error",     32'(bus_error), 32'h1);
        check("tmo_err_address",   err_address, 32'h0400_0100);
        check("tmo_idle_strobes",  32'(s_read | s_write), 32'h0);

        xfer(1'b1, 1'b0, 32'h0900_0000, 32'h0, 4'hF, 0, 0, 0);
        check("tmo_fault2_err_address", err_address, 32'h0400_0100);

        // err_clear on the same edge as a new fault: the fault wins
        xfer(1'b1, 1'b0, 32'h0B00_0000, 32'h0, 4'hF, 0, 0, 1);
        check("coincide_bus_error",   32'(bus_error), 32'h1);
        check("coincide_err_address", err_address, 32'h0B00_0000);
        pulse_clear();

        // Master abort in DECODE on an unmapped address raises nothing
        xfer(1'b1, 1'b0, 32'h0900_0000, 32'h0, 4'hF, 0, 1, 0);
        check("abort_dec_latency",   32'(r_lat), 32'd1);
        check("abort_dec_strobes",   32'(r_strobes), 32'h0);
        check("abort_dec_bus_error", 32'(bus_error), 32'h0);
        check("abort_dec_m_stall",   32'(m_stall), 32'h0);

        // Master abort in ACTIVE while the slave stalls
        xfer(1'b1, 1'b0, 32'h0400_0000, 32'h0, 4'hF, 1000, 3, 0);
        check("abort_act_strobes",   32'(r_strobes), 32'd2);
        check("abort_act_latency",   32'(r_lat), 32'd3);
        check("abort_act_bus_error", 32'(bus_error), 32'h0);
        check("abort_act_idle_strb", 32'(s_read | s_write), 32'h0);

        // Interrupt merge with one cycle of latency
        s_interrupt[0*6 +: 6] = 6'h01;
        s_interrupt[5*6 +: 6] = 6'h20;
        s_interrupt[7*6 +: 6] = 6'h06;
        check("irq_latency", 32'(m_interrupt), 32'h0);
        @(posedge clk);
        #1;
        check("irq_or_a", 32'(m_interrupt), 32'h27);
        s_interrupt[3*6 +: 6] = 6'h10;
        @(posedge clk);
        #1;
        check("irq_or_b", 32'(m_interrupt), 32'h37);
        s_interrupt = '0;
        @(posedge clk);
        #1;
        check("irq_clear", 32'(m_interrupt), 32'h0);

        // Reset asserted mid-transfer drops strobes without waiting for a clock
        s_stall   = 8'h10;
        m_address = 32'h0400_0000;
        m_read    = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_act_s_read_pre", 32'(s_read), 32'h10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_act_s_read",    32'(s_read), 32'h0);
        check("rst_act_m_stall",   32'(m_stall), 32'h0);
        check("rst_act_m_data_rd", m_data_rd, 32'h0);
        m_read  = 1'b0;
        s_stall = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_act_bus_error", 32'(bus_error), 32'h0);

        xfer(1'b1, 1'b0, 32'h0300_0004, 32'h0, 4'hF, 0, 0, 0);
        check("post_rst_latency", 32'(r_lat), 32'd2);
        check("post_rst_data",    r_data, 32'h1234_5678);
        check("post_rst_s_read",  32'(r_rd_seen), 32'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
